// File: rtl/pattern_detect_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// These cover the state width and the KMP-style prefix and failure computations.
package pattern_detect_pkg;

  localparam int S_IDLE = 0;

  function automatic int state_width(input int pat_w);
    return (pat_w > 2) ? $clog2(pat_w) : 1;
  endfunction

  // Longest proper pattern prefix that ends the string "first k pattern bits, then b".
  function automatic int prefix_after(input logic [15:0] pat, input int pat_w,
                                      input int k, input logic b);
    int max_l;
    int j;
    int result;
    bit ok;
    logic s_bit;
    logic p_bit;
    logic [15:0] sh;
    result = 0;
    max_l  = (k + 1 < pat_w) ? k + 1 : pat_w - 1;
    for (int l = 1; l <= max_l; l++) begin
      ok = 1'b1;
      for (int i = 0; i < l; i++) begin
        j = k + 1 - l + i;
        sh = pat >> (pat_w - 1 - j);
        s_bit = (j == k) ? b : sh[0];
        sh = pat >> (pat_w - 1 - i);
        p_bit = sh[0];
        if (s_bit != p_bit) ok = 1'b0;
      end
      if (ok) result = l;
    end
    return result;
  endfunction

  function automatic int border_len(input logic [15:0] pat, input int pat_w);
    return prefix_after(pat, pat_w, pat_w - 1, pat[0]);
  endfunction

endpackage

// File: rtl/pattern_detect_fsm_counter.sv
// Saturating match counter used by the pattern detector when counting is enabled.
// A clear request takes priority over a same-cycle increment.
module pattern_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_detect_fsm.sv
// Serial pattern detector (KMP automaton) with Mealy match pulse and registered copy.
// Define PATTERN_DETECT_CNT_EN to add the saturating match counter and its clear input.
module pattern_detect_fsm
  import pattern_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic                          din,
  input  logic                          restart,
`ifdef PATTERN_DETECT_CNT_EN
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              match_cnt,
`endif
  output logic                          match,
  output logic                          match_q,
  output logic [state_width(PAT_W)-1:0] state_o
);

  localparam int              SW    = state_width(PAT_W);
  localparam logic [SW-1:0]   LAST  = SW'(PAT_W - 1);
  localparam logic [SW-1:0]   IDLE  = SW'(S_IDLE);
  localparam logic [15:0]     PAT16 = 16'(PATTERN);

  logic [SW-1:0] state;
  logic [SW-1:0] state_nxt;
  logic [SW-1:0] next_tbl [PAT_W][2];

  // Transition table is constant: entry for the completing bit holds the pattern border.
  for (genvar k = 0; k < PAT_W; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      assign next_tbl[k][b] = SW'(prefix_after(PAT16, PAT_W, k, 1'(b)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      match_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_q <= match;
    end
  end

  always_comb begin
    state_nxt = state;
    match     = 1'b0;
    if (restart) begin
      state_nxt = IDLE;
    end else if (state > LAST) begin
      state_nxt = IDLE;
    end else if (in_valid) begin
      match = (state == LAST) && (din == PATTERN[0]) && !reset;
      if (match && (OVERLAP == 0)) begin
        state_nxt = IDLE;
      end else begin
        state_nxt = next_tbl[state][din];
      end
    end
  end

  assign state_o = state;

`ifdef PATTERN_DETECT_CNT_EN
  pattern_match_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr),
    .count(match_cnt)
  );
`endif

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// Bench for pattern_detect_fsm: an overlapping and a non-overlapping instance share stimulus
// and are compared against a bit-history model. Counter checks apply with PATTERN_DETECT_CNT_EN.
module tb_pattern_detect_fsm;

  localparam int         PAT_W = 4;
  localparam logic [3:0] PAT   = 4'b1011;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       din;
  logic       restart;
  logic       cnt_clr;
  logic       match_ov, match_q_ov, match_no, match_q_no;
  logic [1:0] state_ov, state_no;
`ifdef PATTERN_DETECT_CNT_EN
  logic [1:0] cnt_ov;
  logic [7:0] cnt_no;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int exp_cnt_ov = 0;
  int exp_cnt_no = 0;
  bit hist_ov[$];
  bit hist_no[$];
  bit exp_m_ov, exp_m_no;
  logic obs_m_ov, obs_m_no;

  always #5 clk = ~clk;

  pattern_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut_ov (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .restart(restart),
`ifdef PATTERN_DETECT_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(cnt_ov),
`endif
    .match(match_ov), .match_q(match_q_ov), .state_o(state_ov)
  );

  pattern_detect_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din), .restart(restart),
`ifdef PATTERN_DETECT_CNT_EN
    .cnt_clr(cnt_clr), .match_cnt(cnt_no),
`endif
    .match(match_no), .match_q(match_q_no), .state_o(state_no)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // True when the history ends with the first k pattern bits (first bit = pattern MSB).
  function automatic bit ends_with_prefix(input bit q[$], input int k);
    if (q.size() < k) return 1'b0;
    for (int i = 0; i < k; i++)
      if (q[q.size() - k + i] != PAT[PAT_W - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_state(input bit q[$]);
    for (int k = PAT_W - 1; k >= 1; k--)
      if (ends_with_prefix(q, k)) return k;
    return 0;
  endfunction

  task automatic clear_model();
    hist_ov.delete();
    hist_no.delete();
    exp_m_ov = 1'b0;
    exp_m_no = 1'b0;
    exp_cnt_ov = 0;
    exp_cnt_no = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_state_ov"}, 32'(state_ov), 32'(model_state(hist_ov)));
    check({tag, "_state_no"}, 32'(state_no), 32'(model_state(hist_no)));
    check({tag, "_match_q_ov"}, 32'(match_q_ov), 32'(exp_m_ov));
    check({tag, "_match_q_no"}, 32'(match_q_no), 32'(exp_m_no));
`ifdef PATTERN_DETECT_CNT_EN
    check({tag, "_cnt_ov"}, 32'(cnt_ov), 32'(exp_cnt_ov));
    check({tag, "_cnt_no"}, 32'(cnt_no), 32'(exp_cnt_no));
`endif
  endtask

  task automatic apply_stimulus(input bit v, input bit d, input bit rs, input bit clr);
    bit t_ov[$];
    bit t_no[$];
    @(negedge clk);
    in_valid = v;
    din      = d;
    restart  = rs;
    cnt_clr  = clr;
    t_ov = hist_ov;
    t_ov.push_back(d);
    t_no = hist_no;
    t_no.push_back(d);
    exp_m_ov = v && !rs && ends_with_prefix(t_ov, PAT_W);
    exp_m_no = v && !rs && ends_with_prefix(t_no, PAT_W);
    #1;
    obs_m_ov = match_ov;
    obs_m_no = match_no;
    check("match_ov", 32'(match_ov), 32'(exp_m_ov));
    check("match_no", 32'(match_no), 32'(exp_m_no));
    @(posedge clk);
    if (rs) begin
      hist_ov.delete();
      hist_no.delete();
    end else if (v) begin
      hist_ov = t_ov;
      if (exp_m_no) hist_no.delete();
      else hist_no = t_no;
    end
    while (hist_ov.size() > PAT_W) void'(hist_ov.pop_front());
    while (hist_no.size() > PAT_W) void'(hist_no.pop_front());
    if (clr) begin
      exp_cnt_ov = 0;
      exp_cnt_no = 0;
    end else begin
      if (exp_m_ov && exp_cnt_ov < 3) exp_cnt_ov++;
      if (exp_m_no && exp_cnt_no < 255) exp_cnt_no++;
    end
    #1;
    check_regs("step");
  endtask

  // Reset is raised between clock edges while a completing bit sits on din.
  task automatic check_output_reset();
    @(negedge clk);
    in_valid = 1'b1;
    din      = 1'b1;
    restart  = 1'b0;
    cnt_clr  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    clear_model();
    check("rst_state_ov", 32'(state_ov), 32'd0);
    check("rst_state_no", 32'(state_no), 32'd0);
    check("rst_match_ov", 32'(match_ov), 32'd0);
    check("rst_match_no", 32'(match_no), 32'd0);
    @(posedge clk);
    #1;
    check_regs("rst");
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  bit dir_stream [7] = '{1, 0, 1, 1, 0, 1, 1};
  bit dir_exp_ov [7] = '{0, 0, 0, 1, 0, 0, 1};
  bit dir_exp_no [7] = '{0, 0, 0, 1, 0, 0, 0};
  int sat_exp    [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    din      = 1'b0;
    restart  = 1'b0;
    cnt_clr  = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_regs("init");
    check("init_match_ov", 32'(match_ov), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Overlapping vs non-overlapping on 1011011.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b1, dir_stream[i], 1'b0, 1'b0);
      check("dir_ov", 32'(obs_m_ov), 32'(dir_exp_ov[i]));
      check("dir_no", 32'(obs_m_no), 32'(dir_exp_no[i]));
      if (i == 3) check("dir_no_idle", 32'(state_no), 32'd0);
    end

    // Idle cycles hold a partial match.
    check_output_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'(i), 1'b0, 1'b0);
      check("hold_state", 32'(state_ov), 32'd3);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_match", 32'(obs_m_ov), 32'd1);

    // Reset mid-pattern discards progress.
    check_output_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check_output_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_match", 32'(obs_m_ov), 32'd0);
    check("post_rst_state", 32'(state_ov), 32'd1);

    // Restart suppresses a completing bit.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    check("restart_match", 32'(obs_m_ov), 32'd0);
    check("restart_state", 32'(state_ov), 32'd0);

`ifdef PATTERN_DETECT_CNT_EN
    // Saturation of the 2-bit counter, then clear beating a coincident match.
    check_output_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 5; m++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      check("sat_cnt", 32'(cnt_ov), 32'(sat_exp[m]));
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_win_match", 32'(obs_m_ov), 32'd1);
    check("clr_win_cnt", 32'(cnt_ov), 32'd0);
`endif

    // Random traffic with occasional restart, clear and reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) check_output_reset();
      apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/pattern_detect_fsm.md
PATTERN_DETECT_FSM -- requirements
Module: pattern_detect_fsm

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: pattern to detect. The MSB is the first bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-004 Parameter CNT_W, default 8: match-counter width.
REQ-005 clk  input  1  sole clock; rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  qualifies din for one cycle.
REQ-008 din  input  1  serial data bit.
REQ-009 restart  input  1  synchronous return to the idle state.
REQ-010 match  output  1  Mealy pulse: the bit currently on din completes the pattern.
REQ-011 match_q  output  1  match registered one cycle later (Moore-style).
REQ-012 state_o  output  $clog2(PAT_W)  current matched-prefix length.
REQ-013 match_cnt  output  CNT_W  saturating match count; present only under the configuration macro.
REQ-014 cnt_clr  input  1  synchronous counter clear; present only under the configuration macro.

Function
REQ-015 State S(k), k = 0..PAT_W-1, SHALL mean the last k accepted bits equal the first k pattern bits. S(0) is idle.
REQ-016 State SHALL change only on a rising clk edge with in_valid=1; with in_valid=0 state holds and match=0.
REQ-017 In S(k), if din = PATTERN[PAT_W-1-k] and k < PAT_W-1, next state SHALL be S(k+1).
REQ-018 On a mismatch, next state SHALL be the longest proper prefix of the pattern that is a suffix of the accepted bits plus din (KMP failure transition). The failure transitions SHALL be computed at elaboration time.
REQ-019 match SHALL be combinational: in_valid & (state = S(PAT_W-1)) & (din = PATTERN[0]). Latency from the final bit is zero cycles.
REQ-020 After a match with OVERLAP=1, next state SHALL be S(f), where f is the length of the longest proper border of PATTERN.
REQ-021 After a match with OVERLAP=0, next state SHALL be S(0).
REQ-022 match_q SHALL equal match delayed by exactly one clk.
REQ-023 restart=1 SHALL force next state to S(0) and suppress match in that cycle, regardless of in_valid.
REQ-024 Unreachable state encodings SHALL transition to S(0) on the next edge.

Reset
REQ-025 reset=1 SHALL immediately set state to S(0), match_q=0, and match_cnt=0, independent of clk.
REQ-026 While reset is high, match SHALL be 0.
REQ-027 Reset asserted mid-pattern SHALL discard partial progress; the first valid bit after release is treated as pattern bit 0.

Configuration
REQ-028 With PATTERN_DETECT_CNT_EN defined, match_cnt and cnt_clr SHALL exist.
REQ-029 With PATTERN_DETECT_CNT_EN defined, match_cnt SHALL increment by 1 on each match.
REQ-030 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-031 When cnt_clr and match occur in the same cycle, cnt_clr SHALL win and the counter becomes 0.
REQ-032 Without PATTERN_DETECT_CNT_EN, match_cnt and cnt_clr ports SHALL be absent and no counter logic SHALL be synthesised.

Structure
REQ-033 Package pattern_detect_pkg SHALL hold the state-width function and a border-length (failure) function.
REQ-034 Package pattern_detect_pkg SHALL hold the idle-state constant S_IDLE = 0.
REQ-035 The counter SHALL be a sub-module pattern_match_counter (parameter CNT_W; inputs clk, reset, inc, clr; output count), instantiated only under PATTERN_DETECT_CNT_EN.

Verification
REQ-036 PATTERN=4'b1011, OVERLAP=1, stream 1,0,1,1,0,1,1 -> match high on bits 4 and 7; match_q high one cycle after each.
REQ-037 Same stream with OVERLAP=0 -> match high on bit 4 only; state_o=0 after bit 4.
REQ-038 Stream 1,0,1 then in_valid=0 for 3 cycles, then 1 -> state_o holds at 3, then match fires on the 1.
REQ-039 Stream 1,0,1, then reset pulse between edges, then 1 -> state_o=0 immediately on reset; no match after release.
REQ-040 CNT_W=2, with PATTERN_DETECT_CNT_EN, 5 matches -> match_cnt = 1,2,3,3,3.
REQ-041 CNT_W=2, with PATTERN_DETECT_CNT_EN, cnt_clr coincident with a match -> match_cnt=0.
